qualidade: RTL and testbench



---
 rtl/qualidade_pkg.sv | 16 +
 rtl/qualidade_if.sv | 23 ++
 rtl/qualidade.sv | 71 +++++++
 tb/tb_qualidade.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/qualidade_pkg.sv
// Shared types and LED codes for the qualidade inspection station.
package qualidade_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MEDINDO   = 2'b01,
        APROVADO  = 2'b10,
        REPROVADO = 2'b11
    } estado_t;

    localparam logic [1:0] LED_IDLE      = 2'b00;
    localparam logic [1:0] LED_MEDINDO   = 2'b01;
    localparam logic [1:0] LED_APROVADO  = 2'b10;
    localparam logic [1:0] LED_REPROVADO = 2'b11;

endpackage

// File: rtl/qualidade_if.sv
// Sensor front-end / LED panel bundle for the inspection station.
interface qualidade_if;

    logic       presenca;
    logic       rgb;
    logic       rgb_valido;
    logic [1:0] leds;

    modport master (
        output presenca,
        output rgb,
        output rgb_valido,
        input  leds
    );

    modport slave (
        input  presenca,
        input  rgb,
        input  rgb_valido,
        output leds
    );

endinterface

// File: rtl/qualidade.sv
// Moore grading FSM: wait for object, wait for colour verdict,
// hold approved/rejected until the object leaves.
module qualidade
    import qualidade_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    qualidade_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    estado_t          estado;
    estado_t          estado_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= IDLE;
            cnt    <= '0;
        end else begin
            estado <= estado_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Removal beats a verdict; a verdict beats the timeout.
    always_comb begin
        estado_nxt = estado;
        cnt_nxt    = cnt;
        unique case (estado)
            IDLE: begin
                if (bus.presenca) begin
                    estado_nxt = MEDINDO;
                    cnt_nxt    = '0;
                end
            end
            MEDINDO: begin
                if (!bus.presenca) begin
                    estado_nxt = IDLE;
                end else if (bus.rgb_valido) begin
                    estado_nxt = bus.rgb ? APROVADO : REPROVADO;
                end else if (cnt == CNT_LAST) begin
                    estado_nxt = REPROVADO;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            APROVADO, REPROVADO: begin
                if (!bus.presenca) begin
                    estado_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        bus.leds = LED_IDLE;
        unique case (estado)
            IDLE:      bus.leds = LED_IDLE;
            MEDINDO:   bus.leds = LED_MEDINDO;
            APROVADO:  bus.leds = LED_APROVADO;
            REPROVADO: bus.leds = LED_REPROVADO;
        endcase
    end

endmodule

// File: tb/tb_qualidade.sv
// Directed-vector bench for the qualidade grading FSM.
module tb_qualidade;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    qualidade_if ifc ();

    qualidade #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] exp);
        vectors++;
        assert (ifc.leds === exp) else begin
            miscompares++;
            $error("FAIL %s: leds=%b expected=%b", tag, ifc.leds, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        ifc.presenca   = 1'b1;
        ifc.rgb        = 1'b0;
        ifc.rgb_valido = 1'b0;

        // reset with object present
        step(); chk("rst_a", 2'b00);
        step(); chk("rst_b", 2'b00);
        rst = 1'b0;
        step(); chk("rst_release", 2'b01);
        ifc.presenca = 1'b0;
        step(); chk("rst_leave", 2'b00);

        // approve
        ifc.presenca = 1'b1;
        step(); chk("apr_meas", 2'b01);
        step(); chk("apr_wait1", 2'b01);
        step(); chk("apr_wait2", 2'b01);
        ifc.rgb = 1'b1; ifc.rgb_valido = 1'b1;
        step(); chk("apr_grade", 2'b10);
        ifc.rgb = 1'b0; ifc.rgb_valido = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); chk("apr_hold", 2'b10);
        end
        ifc.rgb_valido = 1'b1;
        step(); chk("apr_nogrd", 2'b10);
        ifc.rgb_valido = 1'b0;
        ifc.presenca = 1'b0;
        step(); chk("apr_leave", 2'b00);

        // reject by colour, no re-grading
        ifc.presenca = 1'b1;
        step(); chk("rej_meas", 2'b01);
        ifc.rgb_valido = 1'b1; ifc.rgb = 1'b0;
        step(); chk("rej_grade", 2'b11);
        ifc.rgb_valido = 1'b0;
        step(); chk("rej_hold", 2'b11);
        ifc.rgb_valido = 1'b1; ifc.rgb = 1'b1;
        step(); chk("rej_nogrd", 2'b11);
        ifc.rgb_valido = 1'b0; ifc.rgb = 1'b0;
        ifc.presenca = 1'b0;
        step(); chk("rej_leave", 2'b00);

        // early removal
        ifc.presenca = 1'b1;
        step(); chk("early_m1", 2'b01);
        step(); chk("early_m2", 2'b01);
        ifc.presenca = 1'b0;
        step(); chk("early_out", 2'b00);
        ifc.presenca = 1'b1;
        step(); chk("race_meas", 2'b01);
        ifc.presenca = 1'b0;
        ifc.rgb_valido = 1'b1; ifc.rgb = 1'b1;
        step(); chk("race_rm", 2'b00);
        ifc.rgb_valido = 1'b0; ifc.rgb = 1'b0;
        step(); chk("race_idle", 2'b00);

        // timeout: exactly 16 cycles measuring
        ifc.presenca = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(); chk("to_meas", 2'b01);
        end
        step(); chk("to_expire", 2'b11);
        ifc.presenca = 1'b0;
        step(); chk("to_leave", 2'b00);

        // verdict on the expiry edge wins
        ifc.presenca = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(); chk("tov_meas", 2'b01);
        end
        ifc.rgb_valido = 1'b1; ifc.rgb = 1'b1;
        step(); chk("tov_grade", 2'b10);
        ifc.rgb_valido = 1'b0; ifc.rgb = 1'b0;
        ifc.presenca = 1'b0;
        step(); chk("tov_leave", 2'b00);

        // back-to-back objects
        ifc.presenca = 1'b1;
        step(); chk("b2b_m1", 2'b01);
        ifc.rgb_valido = 1'b1; ifc.rgb = 1'b1;
        step(); chk("b2b_apr", 2'b10);
        ifc.rgb_valido = 1'b0; ifc.rgb = 1'b0;
        ifc.presenca = 1'b0;
        step(); chk("b2b_out1", 2'b00);
        ifc.presenca = 1'b1;
        step(); chk("b2b_m2", 2'b01);
        ifc.rgb_valido = 1'b1; ifc.rgb = 1'b0;
        step(); chk("b2b_rej", 2'b11);
        ifc.rgb_valido = 1'b0;
        ifc.presenca = 1'b0;
        step(); chk("b2b_out2", 2'b00);

        // reset mid-inspection
        ifc.presenca = 1'b1;
        step(); chk("mid_meas", 2'b01);
        rst = 1'b1;
        step(); chk("mid_rst", 2'b00);
        rst = 1'b0;
        step(); chk("mid_rel", 2'b01);
        ifc.presenca = 1'b0;
        step(); chk("mid_leave", 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
